// File: rtl/mem_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl_if
//
// Requester-side handshake bundle of the shared memory port controller. It
// carries the instruction-fetch and data request channels and the shared
// read result.
//
//   if_req / if_addr / if_done         fetch channel (level request, done pulse)
//   d_req / d_we / d_addr / d_wdata    data channel request
//   d_done                             data channel done pulse
//   rd_data                            read result, held after the done pulse
//
// Modports:
//   master - the CPU side that raises requests
//   slave  - the port controller that serves them
// -----------------------------------------------------------------------------
interface mem_port_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_done;

    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_done;

    logic [WIDTH-1:0] rd_data;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_done, d_done, rd_data
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_done, d_done, rd_data
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl
//
// Shared-memory port controller for the multi-cycle CPU. Arbitrates fetch and
// data requests onto a single memory bus, waits for variable-latency memory
// handshakes, and forces completion after TIMEOUT cycles without one.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   host              requester channels (mem_port_ctrl_if.slave)
//   readM, writeM     memory read / write strobes
//   address           memory address
//   data              bidirectional memory data bus
//   inputReady        memory read data valid on data
//   ackOutput         memory accepted the write
//   busy              controller is not idle
//   timeout_err       sticky flag, set when any access timed out
//   num_access        count of handshake-completed accesses (wraps)
// -----------------------------------------------------------------------------
module mem_port_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_port_ctrl_if.slave   host,
    output logic             readM,
    output logic             writeM,
    output logic [WIDTH-1:0] address,
    inout  wire  [WIDTH-1:0] data,
    input  logic             inputReady,
    input  logic             ackOutput,
    output logic             busy,
    output logic             timeout_err,
    output logic [WIDTH-1:0] num_access
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t           state;
    logic             sel_data;   // 1: data port granted, 0: fetch port
    logic             op_write;   // latched operation of the granted access
    logic [WIDTH-1:0] wdata_q;
    logic [7:0]       wait_cnt;   // ACCESS cycles spent, including the current one
    logic             handshake;

    // Only the handshake that matches the current operation counts.
    assign handshake = op_write ? ackOutput : inputReady;

    // The bus is driven from registers only, so the tristate enable is glitch-free.
    assign data = writeM ? wdata_q : 'z;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            sel_data     <= 1'b0;
            op_write     <= 1'b0;
            wdata_q      <= '0;
            wait_cnt     <= '0;
            readM        <= 1'b0;
            writeM       <= 1'b0;
            address      <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            num_access   <= '0;
            host.if_done <= 1'b0;
            host.d_done  <= 1'b0;
            host.rd_data <= '0;
        end else begin
            // Done pulses last exactly one cycle.
            host.if_done <= 1'b0;
            host.d_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (host.d_req) begin
                        // Data port has fixed priority; a pending fetch waits.
                        sel_data <= 1'b1;
                        op_write <= host.d_we;
                        address  <= host.d_addr;
                        wdata_q  <= host.d_wdata;
                        readM    <= !host.d_we;
                        writeM   <= host.d_we;
                        wait_cnt <= 8'd1;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end else if (host.if_req) begin
                        sel_data <= 1'b0;
                        op_write <= 1'b0;
                        address  <= host.if_addr;
                        readM    <= 1'b1;
                        writeM   <= 1'b0;
                        wait_cnt <= 8'd1;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end

                ACCESS: begin
                    // A handshake on the TIMEOUT cycle is still a normal completion.
                    if (handshake || wait_cnt == TIMEOUT_CNT) begin
                        readM  <= 1'b0;
                        writeM <= 1'b0;
                        state  <= RESP;
                        if (sel_data) begin
                            host.d_done <= 1'b1;
                        end else begin
                            host.if_done <= 1'b1;
                        end
                        if (handshake) begin
                            num_access <= num_access + WIDTH'(1);
                            if (!op_write) begin
                                host.rd_data <= data;
                            end
                        end else begin
                            timeout_err <= 1'b1;
                            if (!op_write) begin
                                host.rd_data <= '1;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                RESP: begin
                    // No grant here: the requester is still dropping its request.
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    readM  <= 1'b0;
                    writeM <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_port_ctrl
//
// Self-checking bench for mem_port_ctrl. A behavioural model tracks what the
// controller must report (read result, access count, sticky timeout) from the
// access-level rules: an access completes after min(latency + 1, TIMEOUT)
// ACCESS cycles, and only a real handshake counts as an access.
// -----------------------------------------------------------------------------
module tb_mem_port_ctrl;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             readM, writeM, inputReady, ackOutput, busy, timeout_err;
    logic [WIDTH-1:0] address, num_access;
    wire  [WIDTH-1:0] data;

    // Memory-side driver of the shared bus.
    logic             bus_drive;
    logic [WIDTH-1:0] bus_val;
    assign data = bus_drive ? bus_val : 'z;

    mem_port_ctrl_if #(.WIDTH(WIDTH)) host_if ();

    mem_port_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host        (host_if),
        .readM       (readM),
        .writeM      (writeM),
        .address     (address),
        .data        (data),
        .inputReady  (inputReady),
        .ackOutput   (ackOutput),
        .busy        (busy),
        .timeout_err (timeout_err),
        .num_access  (num_access)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [WIDTH-1:0] exp_rd;
    logic [WIDTH-1:0] exp_num;
    logic             exp_err;

    // Flags vector: {readM, writeM, busy, if_done, d_done}
    logic [4:0] got;
    logic [4:0] want;

    // One complete access, starting at a negedge with the controller idle.
    // lat = number of ACCESS cycles before the memory handshakes.
    task automatic run_access(input string tag, input bit is_data, input bit we,
                              input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata,
                              input logic [WIDTH-1:0] rdval, input int lat);
        bit is_wr;
        bit timed_out;
        int n_acc;
        is_wr     = is_data && we;
        timed_out = (lat >= TIMEOUT);
        n_acc     = timed_out ? TIMEOUT : lat + 1;

        if (is_wr) bus_drive = 1'b0;
        if (is_data) begin
            host_if.d_req = 1'b1; host_if.d_we = we;
            host_if.d_addr = addr; host_if.d_wdata = wdata;
        end else begin
            host_if.if_req = 1'b1; host_if.if_addr = addr;
        end

        for (int k = 1; k <= n_acc; k++) begin
            @(negedge clk);
            got  = {readM, writeM, busy, host_if.if_done, host_if.d_done};
            want = {!is_wr, is_wr, 1'b1, 1'b0, 1'b0};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s access%0d flags: got %b want %b", tag, k, got, want);
            end
            n_cmp++;
            if (address !== addr) begin
                n_bad++;
                $display("FAIL %s access%0d address: got %h want %h", tag, k, address, addr);
            end
            if (is_wr) begin
                n_cmp++;
                if (data !== wdata) begin
                    n_bad++;
                    $display("FAIL %s access%0d bus: got %h want %h", tag, k, data, wdata);
                end
            end

            // Requester-side changes after the grant must be ignored.
            if (is_data) begin
                host_if.d_addr = WIDTH'($urandom); host_if.d_wdata = WIDTH'($urandom);
                host_if.d_we = 1'($urandom);
            end

            // Memory side: mismatched handshake noise, real handshake at lat+1.
            inputReady = 1'b0; ackOutput = 1'b0;
            if (is_wr) begin
                inputReady = 1'($urandom);
                if (k == lat + 1) ackOutput = 1'b1;
            end else begin
                ackOutput = 1'($urandom);
                bus_drive = 1'b1;
                bus_val   = WIDTH'($urandom);
                if (k == lat + 1) begin
                    inputReady = 1'b1;
                    bus_val    = rdval;
                end
                #1;
                n_cmp++;
                if (data !== bus_val) begin
                    n_bad++;
                    $display("FAIL %s access%0d read-bus release: got %h want %h", tag, k, data, bus_val);
                end
            end
        end

        // Model: outcome of the access.
        if (timed_out) exp_err = 1'b1;
        else           exp_num = exp_num + WIDTH'(1);
        if (!is_wr)    exp_rd  = timed_out ? '1 : rdval;

        @(negedge clk);  // response cycle
        got  = {readM, writeM, busy, host_if.if_done, host_if.d_done};
        want = {1'b0, 1'b0, 1'b1, !is_data, is_data};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s resp flags: got %b want %b", tag, got, want);
        end
        n_cmp++;
        if (host_if.rd_data !== exp_rd) begin
            n_bad++;
            $display("FAIL %s rd_data: got %h want %h", tag, host_if.rd_data, exp_rd);
        end
        n_cmp++;
        if (num_access !== exp_num) begin
            n_bad++;
            $display("FAIL %s num_access: got %0d want %0d", tag, num_access, exp_num);
        end
        n_cmp++;
        if (timeout_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s timeout_err: got %b want %b", tag, timeout_err, exp_err);
        end

        if (is_data) host_if.d_req = 1'b0;
        else         host_if.if_req = 1'b0;
        inputReady = 1'b0; ackOutput = 1'b0;
        bus_drive = 1'b1; bus_val = 16'h5AC3;
        #1;
        n_cmp++;
        if (data !== 16'h5AC3) begin
            n_bad++;
            $display("FAIL %s resp bus release: got %h want %h", tag, data, 16'h5AC3);
        end

        @(negedge clk);  // back in idle
        got = {readM, writeM, busy, host_if.if_done, host_if.d_done};
        n_cmp++;
        if (got !== 5'b00000) begin
            n_bad++;
            $display("FAIL %s idle flags: got %b want %b", tag, got, 5'b00000);
        end
        n_cmp++;
        if (host_if.rd_data !== exp_rd) begin
            n_bad++;
            $display("FAIL %s rd_data hold: got %h want %h", tag, host_if.rd_data, exp_rd);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        host_if.if_req = 1'b1; host_if.d_req = 1'b1; host_if.d_we = 1'b1;
        host_if.if_addr = 16'h1111; host_if.d_addr = 16'h2222; host_if.d_wdata = 16'h3333;
        bus_drive = 1'b1; bus_val = 16'hA5C3;
        repeat (2) begin
            @(negedge clk);
            got = {readM, writeM, busy, host_if.if_done, host_if.d_done};
            n_cmp++;
            if (got !== 5'b00000) begin
                n_bad++; $display("FAIL reset flags: got %b want %b", got, 5'b00000);
            end
            n_cmp++;
            if ({address, host_if.rd_data, num_access} !== '0) begin
                n_bad++;
                $display("FAIL reset regs: got addr %h rd %h num %h want all 0", address, host_if.rd_data, num_access);
            end
            n_cmp++;
            if (timeout_err !== 1'b0) begin
                n_bad++; $display("FAIL reset timeout_err: got %b want 0", timeout_err);
            end
            n_cmp++;
            if (data !== 16'hA5C3) begin
                n_bad++; $display("FAIL reset bus release: got %h want %h", data, 16'hA5C3);
            end
        end
        host_if.if_req = 1'b0; host_if.d_req = 1'b0;
        reset_n = 1'b1;
        exp_rd = '0; exp_num = '0; exp_err = 1'b0;
        @(negedge clk);
        got = {readM, writeM, busy, host_if.if_done, host_if.d_done};
        n_cmp++;
        if (got !== 5'b00000) begin
            n_bad++; $display("FAIL reset release flags: got %b want %b", got, 5'b00000);
        end
    endtask

    task automatic test_fetch_read();
        run_access("fetch_read", 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hF01C, 0);
    endtask

    task automatic test_arbitration();
        // Fetch and data write raised together; data wins, fetch stays pending.
        host_if.if_req = 1'b1; host_if.if_addr = 16'h0300;
        run_access("arb_write", 1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0000, 3);
        run_access("arb_fetch", 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h8E71, 1);
    endtask

    task automatic test_variable_latency();
        run_access("var_lat", 1'b1, 1'b0, 16'h0A0A, 16'h0000, 16'h6B2D, 7);
    endtask

    task automatic test_timeout();
        run_access("timeout_read", 1'b1, 1'b0, 16'h0777, 16'h0000, 16'h0000, 1000);
        // Handshake exactly on the last allowed cycle completes normally.
        run_access("edge_read", 1'b1, 1'b0, 16'h0778, 16'h0000, 16'h4242, TIMEOUT - 1);
        run_access("timeout_write", 1'b1, 1'b1, 16'h0779, 16'hBEEF, 16'h0000, 1000);
        run_access("timeout_fetch", 1'b0, 1'b0, 16'h077A, 16'h0000, 16'h0000, 1000);
    endtask

    task automatic test_back_to_back();
        bit               pend = 1'b0;
        logic [WIDTH-1:0] pend_addr = '0;
        bit               is_data, we;
        int               lat;
        for (int i = 0; i < 40; i++) begin
            lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 2))
                                              : int'($urandom_range(0, 3));
            if (pend) begin
                run_access("rand_fetch_pend", 1'b0, 1'b0, pend_addr, '0, WIDTH'($urandom), lat);
                pend = 1'b0;
            end else begin
                is_data = 1'($urandom);
                we      = 1'($urandom);
                if (is_data && $urandom_range(0, 2) == 0) begin
                    pend_addr = WIDTH'($urandom);
                    host_if.if_req = 1'b1; host_if.if_addr = pend_addr;
                    pend = 1'b1;
                end
                run_access("rand", is_data, we, WIDTH'($urandom), WIDTH'($urandom),
                           WIDTH'($urandom), lat);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bus_drive = 1'b0;
        host_if.d_req = 1'b1; host_if.d_we = 1'b1;
        host_if.d_addr = 16'h0200; host_if.d_wdata = 16'hC0DE;
        @(negedge clk);  // first ACCESS cycle
        @(negedge clk);  // second ACCESS cycle
        n_cmp++;
        if ({writeM, data} !== {1'b1, 16'hC0DE}) begin
            n_bad++; $display("FAIL midrst pre: got %b/%h want 1/%h", writeM, data, 16'hC0DE);
        end
        reset_n = 1'b0;
        @(negedge clk);
        exp_rd = '0; exp_num = '0; exp_err = 1'b0;
        got = {readM, writeM, busy, host_if.if_done, host_if.d_done};
        n_cmp++;
        if (got !== 5'b00000) begin
            n_bad++; $display("FAIL midrst flags: got %b want %b", got, 5'b00000);
        end
        n_cmp++;
        if ({num_access, timeout_err} !== '0) begin
            n_bad++; $display("FAIL midrst counters: got %h/%b want 0/0", num_access, timeout_err);
        end
        bus_drive = 1'b1; bus_val = 16'h3C5A;
        #1;
        n_cmp++;
        if (data !== 16'h3C5A) begin
            n_bad++; $display("FAIL midrst bus release: got %h want %h", data, 16'h3C5A);
        end
        host_if.d_req = 1'b0;
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            got = {readM, writeM, busy, host_if.if_done, host_if.d_done};
            n_cmp++;
            if (got !== 5'b00000) begin
                n_bad++; $display("FAIL midrst after flags: got %b want %b", got, 5'b00000);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        inputReady = 1'b0; ackOutput = 1'b0;
        bus_drive = 1'b0; bus_val = '0;
        host_if.if_req = 1'b0; host_if.if_addr = '0;
        host_if.d_req = 1'b0; host_if.d_we = 1'b0;
        host_if.d_addr = '0; host_if.d_wdata = '0;
        exp_rd = '0; exp_num = '0; exp_err = 1'b0;

        test_reset();
        test_fetch_read();
        test_arbitration();
        test_variable_latency();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        run_access("post_reset", 1'b0, 1'b0, 16'h0042, 16'h0000, 16'h1357, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Shared-memory port controller for the multi-cycle CPU. It arbitrates instruction-fetch and data requests onto the single memory bus (readM/writeM/address/data inout).
- Waits on variable-latency memory handshakes (inputReady for reads, ackOutput for writes) instead of assuming fixed one-cycle memory.
- Parametrised in word width, with a timeout guard and an access counter for debug.

Parameters:
WIDTH, 16, data and address width in bits
TIMEOUT, 15, maximum cycles spent in ACCESS waiting for a handshake before forced completion (1..255)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
if_req  in  1  fetch request, level, held until if_done
if_addr  in  WIDTH  fetch address
if_done  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, level, held until d_done
d_we  in  1  1 = write, 0 = read (data port only)
d_addr  in  WIDTH  data address
d_wdata  in  WIDTH  write data
d_done  out  1  one-cycle data completion pulse
rd_data  out  WIDTH  read result, valid while if_done/d_done is high, held afterwards
readM  out  1  memory read strobe
writeM  out  1  memory write strobe
address  out  WIDTH  memory address
data  inout  WIDTH  memory data bus
inputReady  in  1  memory: read data valid on data
ackOutput  in  1  memory: write accepted
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on any timeout
num_access  out  WIDTH  count of handshake-completed accesses

Behaviour:
- Reset is synchronous, active-low, on clk (reset_n sampled at posedge).
- Reset values: state=IDLE; readM=0, writeM=0, address=0, rd_data=0; if_done=0, d_done=0; timeout_err=0, num_access=0; data released to 'z.
- All outputs are registered; there is no combinational path from inputs to outputs except the data tristate.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - d_req=1: grant data. Latch d_addr/d_wdata/d_we; go to ACCESS. readM=!d_we, writeM=d_we.
  - Else if_req=1: grant fetch. Latch if_addr; go to ACCESS. readM=1.
  - Data has fixed priority on simultaneous requests; the losing fetch stays pending.
- ACCESS:
  - address = latched address; wait counter increments each cycle.
  - Read: on inputReady=1, rd_data<=data; go to RESP.
  - Write: on ackOutput=1, go to RESP.
  - On handshake, num_access increments (wraps at 2^WIDTH).
  - If the counter reaches TIMEOUT with no handshake, go to RESP anyway:
    - read: rd_data<=all ones;
    - timeout_err<=1;
    - num_access does not increment.
  - A handshake in the same cycle as the TIMEOUT count is a normal completion.
  - inputReady/ackOutput are ignored when they do not match the current operation.
  - readM/writeM deassert on the edge entering RESP.
- RESP:
  - Exactly one of if_done/d_done=1 for one cycle, matching the granted port.
  - No grant is made; go to IDLE next edge.
  - Requester drops req during or after this cycle.
- data bus:
  - Driven with latched wdata only while writeM=1; 'z otherwise.
  - d_wdata/d_addr changes after grant are ignored.
- Latency (request seen at edge N, memory responds in the first ACCESS cycle):
  - strobe high at N+1; done high at N+2; next grant possible at edge N+3.
  - Back-to-back best-case throughput is one access per 3 cycles.
- Reset mid-access: the next reset edge forces IDLE, strobes 0, done 0, bus released; the pending access is dropped with no done pulse.
- timeout_err is cleared only by reset.

Test Plan:
- Reset: reset_n=0 for 2 cycles with if_req=1 and d_req=1 → readM=writeM=0, data=z, busy=0, num_access=0, no done pulses.
- Fetch read: if_addr=16'h0040, inputReady in the first ACCESS cycle with data=16'hF01C → readM high 1 cycle, address=16'h0040, if_done pulse 2 cycles after request, rd_data=16'hF01C, num_access=1.
- Arbitration: if_req and d_req (write, d_addr=16'h0100, d_wdata=16'h1234) raised together, ackOutput after 3 cycles → write served first, data bus=16'h1234 during writeM, d_done pulse; then fetch granted the cycle after IDLE, if_done follows.
- Variable latency: data read with inputReady delayed 7 cycles → readM held 8 cycles, address stable, d_done exactly once, no re-grant during RESP.
- Timeout: TIMEOUT=15, read with no inputReady → d_done after 15 ACCESS cycles, rd_data=16'hFFFF, timeout_err=1 and stays set, num_access unchanged.
- Reset mid-write: reset_n=0 on the 2nd ACCESS cycle of a write → next edge writeM=0, data=z, no d_done, state IDLE.
